// File: rtl/bpu_btb_ras_if.sv
// Fetch-side predictor bus: lookup request/response and ID2 training.
// master = fetch/decode side, slave = predictor.
interface bpu_btb_ras_if;
    // lookup
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_is_ret;
    // training
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_kind;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_is_call;
    logic        upd_mispredict;

    modport master (
        output pc,
        output upd_valid, upd_pc, upd_kind, upd_taken,
        output upd_target, upd_is_call, upd_mispredict,
        input  pred_taken, pred_target, pred_is_ret
    );

    modport slave (
        input  pc,
        input  upd_valid, upd_pc, upd_kind, upd_taken,
        input  upd_target, upd_is_call, upd_mispredict,
        output pred_taken, pred_target, pred_is_ret
    );
endinterface

// File: rtl/bpu_btb_ras.sv
// Tagged direct-mapped BTB with saturating direction counters, plus a
// non-speculative return address stack and lookup/mispredict counters.
// Ports: clk, rst_n (async, active-low), stall, bus (slave: pc lookup,
// pred_* response, upd_* training), ras_top, ras_count, stat_lookups,
// stat_mispred.
module bpu_btb_ras #(
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_BITS    = 8,
    parameter int CNT_BITS    = 2,
    parameter int RAS_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    bpu_btb_ras_if.slave                 bus,
    output logic [31:0]                  ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic [31:0]                  stat_lookups,
    output logic [31:0]                  stat_mispred
);

    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int RP  = $clog2(RAS_DEPTH);

    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_WEAK =
        CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [RP:0]   RAS_FULL = (RP + 1)'(RAS_DEPTH);
    localparam logic [RP-1:0] ONE_P    = RP'(1);

    localparam logic [1:0] K_COND = 2'd0;
    localparam logic [1:0] K_RET  = 2'd3;

    // ---------------- storage ----------------
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0]    tag_q [BTB_ENTRIES];
    logic [1:0]             kind_q[BTB_ENTRIES];
    logic [CNT_BITS-1:0]    cnt_q [BTB_ENTRIES];
    logic [31:0]            tgt_q [BTB_ENTRIES];

    // sp_q points at the next free slot; the top lives at sp_q-1.
    logic [31:0] ras_q [RAS_DEPTH];
    logic [RP-1:0] sp_q;
    logic [RP:0]   ras_cnt_q;

    logic [31:0] look_q;
    logic [31:0] mis_q;

    // ---------------- lookup ----------------
    logic [IDX-1:0]      l_idx;
    logic [TAG_BITS-1:0] l_tag;
    logic                l_hit;
    logic                l_taken;
    logic                l_ret;
    logic [RP-1:0]       top_ptr;
    logic                ras_nonempty;

    assign l_idx = bus.pc[IDX+1:2];
    assign l_tag = bus.pc[IDX+TAG_BITS+1:IDX+2];

    assign top_ptr      = sp_q - ONE_P;
    assign ras_nonempty = (ras_cnt_q != '0);

    assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_taken = l_hit &&
                     ((kind_q[l_idx] != K_COND) ||
                      cnt_q[l_idx][CNT_BITS-1]);
    // A return with an empty stack falls back to the stored target.
    assign l_ret   = l_taken && (kind_q[l_idx] == K_RET) &&
                     ras_nonempty;

    assign ras_top   = ras_nonempty ? ras_q[top_ptr] : '0;
    assign ras_count = ras_cnt_q;

    assign bus.pred_taken  = l_taken;
    assign bus.pred_is_ret = l_ret;
    assign bus.pred_target = !l_taken ? 32'd0 :
                             l_ret    ? ras_top :
                                        tgt_q[l_idx];

    assign stat_lookups = look_q;
    assign stat_mispred = mis_q;

    // ---------------- training ----------------
    logic                upd_en;
    logic [IDX-1:0]      u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;
    logic                u_same;
    logic [CNT_BITS-1:0] u_cnt;
    logic                btb_we;
    logic [CNT_BITS-1:0] w_cnt;
    logic [31:0]         w_tgt;

    assign upd_en = bus.upd_valid && !stall;
    assign u_idx  = bus.upd_pc[IDX+1:2];
    assign u_tag  = bus.upd_pc[IDX+TAG_BITS+1:IDX+2];
    assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_same = (kind_q[u_idx] == bus.upd_kind);
    assign u_cnt  = cnt_q[u_idx];

    always_comb begin
        btb_we = 1'b0;
        w_cnt  = u_cnt;
        w_tgt  = tgt_q[u_idx];
        unique case (1'b1)
            u_hit && u_same && (bus.upd_kind == K_COND): begin
                btb_we = 1'b1;
                if (bus.upd_taken) begin
                    w_cnt = (u_cnt == CNT_MAX) ? u_cnt
                                               : u_cnt + 1'b1;
                    w_tgt = bus.upd_target;
                end else begin
                    w_cnt = (u_cnt == '0) ? u_cnt
                                          : u_cnt - 1'b1;
                end
            end
            u_hit && u_same && (bus.upd_kind != K_COND): begin
                btb_we = 1'b1;
                w_tgt  = bus.upd_target;
            end
            // kind change on a hit, or a taken miss: fresh entry
            (u_hit && !u_same) || (!u_hit && bus.upd_taken): begin
                btb_we = 1'b1;
                w_cnt  = CNT_WEAK;
                w_tgt  = bus.upd_target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (upd_en && btb_we) begin
            valid_q[u_idx] <= 1'b1;
            cnt_q[u_idx]   <= w_cnt;
        end
    end

    // Tag/kind/target are only meaningful under a set valid bit,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (upd_en && btb_we) begin
            tag_q[u_idx]  <= u_tag;
            kind_q[u_idx] <= bus.upd_kind;
            tgt_q[u_idx]  <= w_tgt;
        end
    end

    // ---------------- return stack ----------------
    logic        ras_pop;
    logic        ras_push;
    logic [31:0] ret_addr;

    assign ras_pop  = upd_en && (bus.upd_kind == K_RET) &&
                      ras_nonempty;
    assign ras_push = upd_en && bus.upd_is_call;
    // return lands after the delay slot
    assign ret_addr = bus.upd_pc + 32'd8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q      <= '0;
            ras_cnt_q <= '0;
        end else begin
            case ({ras_pop, ras_push})
                2'b01: begin
                    // full stack wraps over its oldest slot
                    sp_q <= sp_q + ONE_P;
                    if (ras_cnt_q != RAS_FULL) begin
                        ras_cnt_q <= ras_cnt_q + 1'b1;
                    end
                end
                2'b10: begin
                    sp_q      <= top_ptr;
                    ras_cnt_q <= ras_cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) begin
            // pop+push replaces the top in place
            if (ras_pop) begin
                ras_q[top_ptr] <= ret_addr;
            end else begin
                ras_q[sp_q] <= ret_addr;
            end
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            look_q <= '0;
            mis_q  <= '0;
        end else if (!stall) begin
            look_q <= look_q + 32'd1;
            if (bus.upd_valid && bus.upd_mispredict) begin
                mis_q <= mis_q + 32'd1;
            end
        end
    end

    // pc/upd_pc bits outside idx/tag do not take part in prediction
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.pc, bus.upd_pc};

endmodule

// File: tb/tb_bpu_btb_ras.sv
// Scoreboard bench for bpu_btb_ras: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_bpu_btb_ras;

    localparam int N    = 64;
    localparam int TB   = 8;
    localparam int CB   = 2;
    localparam int RD   = 8;
    localparam int IDXB = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] ras_top;
    logic [3:0]  ras_count;
    logic [31:0] st_look;
    logic [31:0] st_mis;

    always #5 clk = ~clk;

    bpu_btb_ras_if bif();

    bpu_btb_ras #(
        .BTB_ENTRIES(N),
        .TAG_BITS   (TB),
        .CNT_BITS   (CB),
        .RAS_DEPTH  (RD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .bus         (bif.slave),
        .ras_top     (ras_top),
        .ras_count   (ras_count),
        .stat_lookups(st_look),
        .stat_mispred(st_mis)
    );

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] tgt;
        logic        ret;
        logic [31:0] top;
        logic [31:0] cnt;
        logic [31:0] sl;
        logic [31:0] sm;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // reference model: per-index entry records, RAS as a plain list
    bit          mv  [N];
    int unsigned mtag[N];
    int          mkind[N];
    int          mcnt[N];
    int unsigned mtgt[N];
    int unsigned mras[$];
    int unsigned mlook;
    int unsigned mmis;

    function automatic void m_clear();
        for (int i = 0; i < N; i++) begin
            mv[i]   = 0;
            mcnt[i] = 0;
        end
        mras.delete();
        mlook = 0;
        mmis  = 0;
    endfunction

    function automatic exp_t m_lookup(string n, logic [31:0] pc);
        exp_t e;
        int i;
        int unsigned t;
        bit hit;
        i = int'((pc >> 2) % N);
        t = (pc >> (IDXB + 2)) % (1 << TB);
        hit = mv[i] && (mtag[i] == t);
        e.name = n;
        e.pt   = hit && (mkind[i] != 0 || mcnt[i] >= (1 << (CB - 1)));
        e.ret  = 0;
        e.tgt  = 0;
        if (e.pt) begin
            if (mkind[i] == 3 && mras.size() > 0) begin
                e.tgt = mras[$];
                e.ret = 1;
            end else begin
                e.tgt = mtgt[i];
            end
        end
        e.top = (mras.size() > 0) ? mras[$] : 0;
        e.cnt = mras.size();
        e.sl  = mlook;
        e.sm  = mmis;
        return e;
    endfunction

    function automatic void m_update(logic [31:0] upc, int k, bit tk,
                                     logic [31:0] tg, bit call);
        int i;
        int unsigned t;
        bit hit;
        i = int'((upc >> 2) % N);
        t = (upc >> (IDXB + 2)) % (1 << TB);
        hit = mv[i] && (mtag[i] == t);
        if (hit && mkind[i] == k) begin
            if (k == 0) begin
                if (tk) begin
                    if (mcnt[i] < (1 << CB) - 1) mcnt[i]++;
                    mtgt[i] = tg;
                end else if (mcnt[i] > 0) begin
                    mcnt[i]--;
                end
            end else begin
                mtgt[i] = tg;
            end
        end else if (hit || tk) begin
            mv[i]    = 1;
            mtag[i]  = t;
            mkind[i] = k;
            mcnt[i]  = 1 << (CB - 1);
            mtgt[i]  = tg;
        end
        if (k == 3 && mras.size() > 0) void'(mras.pop_back());
        if (call) begin
            mras.push_back(upc + 32'd8);
            if (mras.size() > RD) void'(mras.pop_front());
        end
    endfunction

    function automatic void chk(string n, logic [31:0] a,
                                logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".taken"}, 32'(bif.pred_taken), 32'(e.pt));
            chk({e.name, ".target"}, bif.pred_target, e.tgt);
            chk({e.name, ".is_ret"}, 32'(bif.pred_is_ret), 32'(e.ret));
            chk({e.name, ".ras_top"}, ras_top, e.top);
            chk({e.name, ".ras_count"}, 32'(ras_count), e.cnt);
            chk({e.name, ".lookups"}, st_look, e.sl);
            chk({e.name, ".mispred"}, st_mis, e.sm);
        end
    end

    task automatic step(string n, logic [31:0] pc, bit uv,
                        logic [31:0] upc, int k, bit tk,
                        logic [31:0] tg, bit call, bit mis, bit st,
                        bit mrst);
        bif.pc             = pc;
        bif.upd_valid      = uv;
        bif.upd_pc         = upc;
        bif.upd_kind       = 2'(k);
        bif.upd_taken      = tk;
        bif.upd_target     = tg;
        bif.upd_is_call    = call;
        bif.upd_mispredict = mis;
        stall              = st;
        sb.push_back(m_lookup(n, pc));
        @(negedge clk);
        #1;
        if (mrst) rst_n = 1'b0;
        @(posedge clk);
        if (!rst_n) begin
            m_clear();
        end else if (!st) begin
            mlook++;
            if (uv && mis) mmis++;
            if (uv) m_update(upc, k, tk, tg, call);
        end
        #1;
    endtask

    task automatic look(string n, logic [31:0] pc);
        step(n, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(string n, logic [31:0] upc, int k, bit tk,
                       logic [31:0] tg, bit call, bit mis, bit st);
        step(n, upc, 1, upc, k, tk, tg, call, mis, st, 0);
    endtask

    function automatic logic [31:0] rpc();
        return 32'h8000_0000 | (($urandom % 3) << (IDXB + 2)) |
               (($urandom % 6) << 2);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        m_clear();
        look("rst_a", 32'hBFC0_0000);
        look("rst_b", 32'hBFC0_0000);
        rst_n = 1'b1;
        look("rst_chk", 32'hBFC0_0000);

        upd("br_t", 32'hBFC0_0010, 0, 1, 32'hBFC0_0100, 0, 0, 0);
        look("br_hit", 32'hBFC0_0010);
        upd("br_nt1", 32'hBFC0_0010, 0, 0, 32'h0, 0, 1, 0);
        upd("br_nt2", 32'hBFC0_0010, 0, 0, 32'h0, 0, 0, 0);
        look("br_cnt0", 32'hBFC0_0010);

        look("alias_miss", 32'hBFC0_0110);
        upd("alias_alloc", 32'hBFC0_0110, 0, 1, 32'hBFC0_0200, 0, 0, 0);
        look("alias_hit", 32'hBFC0_0110);
        look("alias_orig", 32'hBFC0_0010);

        upd("call", 32'h8000_0020, 1, 1, 32'h8000_0200, 1, 1, 0);
        look("call_chk", 32'h8000_0200);
        upd("ret_pop", 32'h8000_0200, 3, 1, 32'h8000_1230, 0, 1, 0);
        look("ret_empty", 32'h8000_0200);
        upd("call2", 32'h8000_0020, 1, 1, 32'h8000_0200, 1, 0, 0);
        look("ret_ras", 32'h8000_0200);
        upd("ret_push", 32'h8000_0300, 3, 1, 32'h8000_0028, 1, 0, 0);

        for (int i = 0; i < 9; i++) begin
            upd("push", 32'h8000_1000 + 32'(i * 16), 1, 1,
                32'h8000_3000, 1, 0, 0);
        end
        look("full_chk", 32'h8000_2000);
        for (int i = 0; i < 9; i++) begin
            upd("pop", 32'h8000_2000, 3, 1, 32'h8000_0028, 0, 0, 0);
        end
        look("empty_chk", 32'h8000_2000);

        upd("stall", 32'h8000_0040, 0, 1, 32'h8000_0400, 1, 1, 1);
        look("stall_chk", 32'h8000_0040);
        upd("unstall", 32'h8000_0040, 0, 1, 32'h8000_0400, 1, 1, 0);
        look("unstall_chk", 32'h8000_0040);

        step("mid_rst", 32'h8000_0040, 1, 32'h8000_0080, 1, 1,
             32'h8000_0800, 1, 1, 0, 1);
        look("in_rst", 32'h8000_0040);
        rst_n = 1'b1;
        look("post_rst", 32'h8000_0080);

        for (int c = 0; c < 1500; c++) begin
            int k;
            bit tk;
            k  = int'($urandom % 4);
            tk = (k != 0) ? 1'b1 : 1'(($urandom % 2));
            step("rnd", rpc(), ($urandom % 10) < 7, rpc(), k, tk,
                 $urandom & 32'hFFFF_FFFC, ($urandom % 4) == 0,
                 1'($urandom % 2), ($urandom % 10) == 0, 0);
        end
        stall = 1'b0;

        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
